// File: rtl/fetch_unit.sv
// Program-counter / instruction-register stage behind the control unit.
// It issues instruction and LDI-immediate reads to a variable-latency memory.
// `stall` holds the CU until the memory answers, or forever once a read times out.
// Optional feature: define FETCH_COUNT_EN to add the fetch_cnt output, which
// counts completed instruction fetches.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_ld,
  input  logic        pc_sel,
  input  logic        pc_inc,
  input  logic        ir_ld,
  input  logic [15:0] jmp_tgt,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic [15:0] imm,
  output logic        stall,
  output logic        fault
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitIr, StWaitImm, StFault} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        inc_q, inc_d;   // pc_inc captured at request time
  logic [7:0]  cnt_q, cnt_d;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      imm_q   <= 16'h0000;
      addr_q  <= 16'h0000;
      rd_q    <= 1'b0;
      inc_q   <= 1'b0;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath updates and the stall handshake
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    imm_d   = imm_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (pc_ld) begin
          // Branch wins over any fetch request in the same cycle
          pc_d = pc_sel ? jmp_tgt : pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
        end else if (ir_ld || pc_inc) begin
          addr_d  = pc_q;
          rd_d    = 1'b1;
          inc_d   = pc_inc;
          cnt_d   = 8'h00;
          state_d = ir_ld ? StWaitIr : StWaitImm;
          stall   = 1'b1;
        end
      end
      StWaitIr, StWaitImm: begin
        stall = ~mem_ack;
        if (mem_ack) begin
          if (state_q == StWaitIr) begin
            ir_d = mem_rdata;
          end else begin
            imm_d = mem_rdata;
          end
          if (inc_q) begin
            pc_d = pc_q + 16'd1;
          end
          rd_d    = 1'b0;
          cnt_d   = 8'h00;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TimeoutCnt) begin
            rd_d    = 1'b0;
            state_d = StFault;
          end
        end
      end
      StFault: begin
        stall = 1'b1;
        rd_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign ir       = ir_q;
  assign pc       = pc_q;
  assign imm      = imm_q;
  assign fault    = (state_q == StFault);

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt_q;

  // Count completed instruction fetches; immediates are not counted
  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt_q <= 16'h0000;
    end else if (state_q == StWaitIr && mem_ack) begin
      fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of CU operations plus sequences
// for timeout, reset during a transfer and the optional fetch counter.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ld, pc_sel, pc_inc, ir_ld, mem_ack;
  logic [15:0] jmp_tgt, mem_rdata;
  logic [15:0] mem_addr, ir, pc, imm;
  logic        mem_rd, stall, fault;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_cnt;
`endif

  fetch_unit #(.RESET_PC(16'h0010), .TIMEOUT(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_ld    (pc_ld),
    .pc_sel   (pc_sel),
    .pc_inc   (pc_inc),
    .ir_ld    (ir_ld),
    .jmp_tgt  (jmp_tgt),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .ir       (ir),
    .pc       (pc),
    .imm      (imm),
    .stall    (stall),
    .fault    (fault)
`ifdef FETCH_COUNT_EN
    ,
    .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_ld, pc_sel, pc_inc, ir_ld;
    logic [15:0] jmp;
    int          lat;     // cycles from request to ack
    logic [15:0] rdata, addr, epc, eir, eimm;
  } vec_t;

  typedef struct packed {
    logic [15:0] pc, ir, imm;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic l, input logic s, input logic inc, input logic ird,
                              input logic [15:0] jmp, input int lat, input logic [15:0] rdata,
                              input logic [15:0] addr, input logic [15:0] epc,
                              input logic [15:0] eir, input logic [15:0] eimm);
    vec_t v;
    v.pc_ld = l; v.pc_sel = s; v.pc_inc = inc; v.ir_ld = ird;
    v.jmp = jmp; v.lat = lat; v.rdata = rdata; v.addr = addr;
    v.epc = epc; v.eir = eir; v.eimm = eimm;
    return v;
  endfunction

  // Entered and left at a negedge with CU inputs idle.
  task automatic apply(input vec_t v, input int id);
    logic fetch;
    exp_t e;
    fetch   = !v.pc_ld && (v.ir_ld || v.pc_inc);
    pc_ld   = v.pc_ld;
    pc_sel  = v.pc_sel;
    pc_inc  = v.pc_inc;
    ir_ld   = v.ir_ld;
    jmp_tgt = v.jmp;
    #1;
    check($sformatf("v%0d_stall_req", id), 16'(stall), 16'(fetch));
    if (fetch) sb.push_back('{pc: v.epc, ir: v.eir, imm: v.eimm});
    @(posedge clk);
    @(negedge clk);
    if (fetch) begin
      for (int k = 1; k <= v.lat; k++) begin
        if (k == v.lat) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_rdata = ~v.rdata;
        end
        #1;
        check($sformatf("v%0d_w%0d_stall", id, k), 16'(stall), 16'(k != v.lat));
        check($sformatf("v%0d_w%0d_rd", id, k), 16'(mem_rd), 16'h1);
        check($sformatf("v%0d_w%0d_addr", id, k), mem_addr, v.addr);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
    pc_ld = 1'b0; pc_sel = 1'b0; pc_inc = 1'b0; ir_ld = 1'b0;
    if (fetch) begin
      if (sb.size() == 0) begin
        check($sformatf("v%0d_sb_empty", id), 16'h0, 16'h1);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_pc", id), pc, e.pc);
        check($sformatf("v%0d_ir", id), ir, e.ir);
        check($sformatf("v%0d_imm", id), imm, e.imm);
      end
    end else begin
      check($sformatf("v%0d_pc", id), pc, v.epc);
      check($sformatf("v%0d_ir", id), ir, v.eir);
      check($sformatf("v%0d_imm", id), imm, v.eimm);
    end
    check($sformatf("v%0d_rd_done", id), 16'(mem_rd), 16'h0);
  endtask

  vec_t tbl[11];
  vec_t cnt_tbl[4];

  initial begin
    // pc_ld pc_sel pc_inc ir_ld jmp lat rdata addr exp_pc exp_ir exp_imm
    tbl[0]  = mk(0, 0, 1, 1, 16'h0000, 3, 16'hE0C2, 16'h0010, 16'h0011, 16'hE0C2, 16'h0000);
    tbl[1]  = mk(1, 1, 0, 0, 16'h001F, 0, 16'h0000, 16'h0000, 16'h001F, 16'hE0C2, 16'h0000);
    tbl[2]  = mk(0, 0, 1, 1, 16'h0000, 1, 16'hF8FE, 16'h001F, 16'h0020, 16'hF8FE, 16'h0000);
    tbl[3]  = mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h001E, 16'hF8FE, 16'h0000);
    tbl[4]  = mk(1, 1, 0, 0, 16'h1234, 0, 16'h0000, 16'h0000, 16'h1234, 16'hF8FE, 16'h0000);
    tbl[5]  = mk(0, 0, 1, 0, 16'h0000, 2, 16'h5A5A, 16'h1234, 16'h1235, 16'hF8FE, 16'h5A5A);
    tbl[6]  = mk(0, 0, 0, 1, 16'h0000, 1, 16'h0005, 16'h1235, 16'h1235, 16'h0005, 16'h5A5A);
    tbl[7]  = mk(1, 0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h123A, 16'h0005, 16'h5A5A);
    tbl[8]  = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h123A, 16'h0005, 16'h5A5A);
    tbl[9]  = mk(1, 1, 0, 0, 16'hFFFF, 0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0005, 16'h5A5A);
    tbl[10] = mk(0, 0, 1, 0, 16'h0000, 1, 16'h00AA, 16'hFFFF, 16'h0000, 16'h0005, 16'h00AA);

    cnt_tbl[0] = mk(0, 0, 1, 1, 16'h0000, 1, 16'h1111, 16'h0010, 16'h0011, 16'h1111, 16'h0000);
    cnt_tbl[1] = mk(0, 0, 1, 0, 16'h0000, 1, 16'h2222, 16'h0011, 16'h0012, 16'h1111, 16'h2222);
    cnt_tbl[2] = mk(0, 0, 1, 1, 16'h0000, 2, 16'h3333, 16'h0012, 16'h0013, 16'h3333, 16'h2222);
    cnt_tbl[3] = mk(0, 0, 0, 1, 16'h0000, 1, 16'h4444, 16'h0013, 16'h0013, 16'h4444, 16'h2222);

    reset = 1'b0;
    pc_ld = 1'b0; pc_sel = 1'b0; pc_inc = 1'b0; ir_ld = 1'b0;
    jmp_tgt = 16'h0000; mem_rdata = 16'h0000; mem_ack = 1'b0;

    // Reset for two cycles
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_pc", pc, 16'h0010);
    check("rst_ir", ir, 16'h0000);
    check("rst_imm", imm, 16'h0000);
    check("rst_rd", 16'(mem_rd), 16'h0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_stall", 16'(stall), 16'h0);
    check("rst_fault", 16'(fault), 16'h0);

    for (int i = 0; i < 11; i++) apply(tbl[i], i);

    // Timeout: instruction fetch at pc=0000 never acknowledged
    ir_ld = 1'b1;
    #1;
    check("to_req_stall", 16'(stall), 16'h1);
    @(posedge clk);
    @(negedge clk);
    for (int w = 1; w <= 15; w++) begin
      #1;
      check($sformatf("to_w%0d_stall", w), 16'(stall), 16'h1);
      check($sformatf("to_w%0d_fault", w), 16'(fault), 16'h0);
      check($sformatf("to_w%0d_rd", w), 16'(mem_rd), 16'h1);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("to_fault", 16'(fault), 16'h1);
    check("to_rd", 16'(mem_rd), 16'h0);
    check("to_stall", 16'(stall), 16'h1);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    ir_ld   = 1'b0;
    #1;
    check("to_late_ir", ir, 16'h0005);
    check("to_late_pc", pc, 16'h0000);
    check("to_late_imm", imm, 16'h00AA);
    check("to_late_fault", 16'(fault), 16'h1);
    check("to_late_stall", 16'(stall), 16'h1);
    check("to_late_rd", 16'(mem_rd), 16'h0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("to_rst_fault", 16'(fault), 16'h0);
    check("to_rst_pc", pc, 16'h0010);
    check("to_rst_ir", ir, 16'h0000);
    check("to_rst_stall", 16'(stall), 16'h0);

    // Reset during WAIT_IR, ack arriving in the following cycle
    ir_ld  = 1'b1;
    pc_inc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ir_ld  = 1'b0;
    pc_inc = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    check("mid_stall_ack", 16'(stall), 16'h0);
    check("mid_rd_ack", 16'(mem_rd), 16'h0);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("mid_ir", ir, 16'h0000);
    check("mid_pc", pc, 16'h0010);
    check("mid_stall", 16'(stall), 16'h0);
    check("mid_rd", 16'(mem_rd), 16'h0);
`ifdef FETCH_COUNT_EN
    check("mid_fetch_cnt", fetch_cnt, 16'h0000);
`endif

    // Back-to-back fetches: three instructions and one immediate
    for (int i = 0; i < 4; i++) apply(cnt_tbl[i], 20 + i);
`ifdef FETCH_COUNT_EN
    check("fetch_cnt", fetch_cnt, 16'h0003);
`endif
    check("sb_drained", 16'(sb.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
